pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline register for the MIPS pipeline boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a PC and a payload word under a valid/ready handshake. A one-entry skid buffer keeps in_ready registered, so stalls do not form a combinational path back through the pipeline. A flush squashes all held contents into bubbles (NOP payload, valid low).

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_sat_counter.sv | 32 +++
 rtl/pipe_stage_reg.sv | 151 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline boundary registers.
package pipe_pkg;

  localparam int unsigned MIPS_PC_W    = 32;
  localparam int unsigned MIPS_INSTR_W = 32;

  // sll $0,$0,0 encodes as all zeros; used as the bubble payload.
  localparam logic [MIPS_INSTR_W-1:0] MIPS_NOP = 32'h0000_0000;

  // Occupancy encoding {s_valid, m_valid}; 2'b10 is unreachable.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module pipe_sat_counter #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               inc_i,
  output logic [COUNT_W-1:0] count_o
);

  logic [COUNT_W-1:0] count_q, count_d;

  // Increment on request, stick at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with one-entry skid buffer and flush.
// in_ready is a pure register output (~skid valid), so stalls never form a
// combinational path upstream. Optional performance counters are enabled by
// defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W   = MIPS_INSTR_W,
  parameter int unsigned        PC_W     = MIPS_PC_W,
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(MIPS_NOP),
  parameter int unsigned        COUNT_W  = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [DATA_W-1:0]  out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [COUNT_W-1:0] stall_cnt,
  output logic [COUNT_W-1:0] flush_cnt
`endif
);

  if (COUNT_W < 1) begin : g_bad_count_w
    $error("COUNT_W must be at least 1");
  end

  logic              m_valid_q, m_valid_d;
  logic [PC_W-1:0]   m_pc_q, m_pc_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [PC_W-1:0]   s_pc_q, s_pc_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              acc, drn;

  assign acc = in_valid & ~s_valid_q;
  assign drn = m_valid_q & out_ready;

  // Next-state for main/skid; empty slots always hold PC 0 and NOP so the
  // outputs can come straight from the registers.
  always_comb begin
    m_valid_d = m_valid_q;
    m_pc_d    = m_pc_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_pc_d    = s_pc_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_pc_d    = '0;
      m_data_d  = NOP_WORD;
      s_valid_d = 1'b0;
      s_pc_d    = '0;
      s_data_d  = NOP_WORD;
    end else begin
      unique case ({s_valid_q, m_valid_q})
        ST_EMPTY: begin
          if (acc) begin
            m_valid_d = 1'b1;
            m_pc_d    = in_pc;
            m_data_d  = in_data;
          end
        end
        ST_BUSY: begin
          if (acc && drn) begin
            m_pc_d   = in_pc;
            m_data_d = in_data;
          end else if (acc) begin
            s_valid_d = 1'b1;
            s_pc_d    = in_pc;
            s_data_d  = in_data;
          end else if (drn) begin
            m_valid_d = 1'b0;
            m_pc_d    = '0;
            m_data_d  = NOP_WORD;
          end
        end
        ST_FULL: begin
          if (drn) begin
            m_pc_d    = s_pc_q;
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
            s_pc_d    = '0;
            s_data_d  = NOP_WORD;
          end
        end
        default: begin
          // Unreachable encoding: fall back to empty.
          m_valid_d = 1'b0;
          m_pc_d    = '0;
          m_data_d  = NOP_WORD;
          s_valid_d = 1'b0;
          s_pc_d    = '0;
          s_data_d  = NOP_WORD;
        end
      endcase
    end
  end

  // Main and skid registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_pc_q    <= '0;
      m_data_q  <= NOP_WORD;
      s_valid_q <= 1'b0;
      s_pc_q    <= '0;
      s_data_q  <= NOP_WORD;
    end else begin
      m_valid_q <= m_valid_d;
      m_pc_q    <= m_pc_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_pc_q    <= s_pc_d;
      s_data_q  <= s_data_d;
    end
  end

  assign in_ready  = ~s_valid_q;
  assign out_valid = m_valid_q;
  assign out_pc    = m_pc_q;
  assign out_data  = m_data_q;

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(
    .COUNT_W (COUNT_W)
  ) u_stall_cnt (
    .clock_i (clock),
    .reset_i (reset),
    .inc_i   (m_valid_q & ~out_ready),
    .count_o (stall_cnt)
  );

  pipe_sat_counter #(
    .COUNT_W (COUNT_W)
  ) u_flush_cnt (
    .clock_i (clock),
    .reset_i (reset),
    .inc_i   (flush),
    .count_o (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a FIFO scoreboard model.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [3:0]  stall_cnt;
  logic [3:0]  flush_cnt;
`endif

  entry_t      sb[$];
  int unsigned stall_m = 0;
  int unsigned flush_m = 0;
  int          passed = 0;
  int          total = 0;

  always #5 clock = ~clock;

  pipe_stage_reg #(
    .DATA_W   (32),
    .PC_W     (32),
    .NOP_WORD (32'h0000_0000),
    .COUNT_W  (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the scoreboard's view of occupancy.
  task automatic check_outputs(input string tag);
    logic [31:0] exp_pc;
    logic [31:0] exp_data;
    exp_pc   = (sb.size() != 0) ? sb[0].pc : 32'h0;
    exp_data = (sb.size() != 0) ? sb[0].data : 32'h0;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(sb.size() < 2));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(sb.size() != 0));
    check({tag, ".out_pc"}, out_pc, exp_pc);
    check({tag, ".out_data"}, out_data, exp_data);
`ifdef PIPE_STAGE_PERF_EN
    check({tag, ".stall_cnt"}, 32'(stall_cnt), stall_m);
    check({tag, ".flush_cnt"}, 32'(flush_cnt), flush_m);
`endif
  endtask

  // Advance one clock: update the model from pre-edge inputs, then check.
  task automatic tick(input string tag);
    logic acc, drn;
    acc = in_valid && (sb.size() < 2);
    drn = out_ready && (sb.size() != 0);
    if ((sb.size() != 0) && !out_ready && stall_m < 15) stall_m++;
    if (flush && flush_m < 15) flush_m++;
    if (flush) begin
      sb.delete();
    end else begin
      if (drn) void'(sb.pop_front());
      if (acc) sb.push_back('{pc: in_pc, data: in_data});
    end
    @(posedge clock);
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] data);
    in_valid = v;
    in_pc    = pc;
    in_data  = data;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    sb.delete();
    stall_m = 0;
    flush_m = 0;
    #1 check_outputs("reset_async");
    #1 reset = 1'b0;
  endtask

  initial begin
    // Power-on reset
    #12 reset = 1'b0;
    check_outputs("por");

    // 1: fill to FULL, then reset mid-cycle
    out_ready = 1'b0;
    drive(1'b1, 32'h10, 32'h1111_0001); tick("t1_a");
    drive(1'b1, 32'h14, 32'h1111_0002); tick("t1_b");
    drive(1'b0, 32'h0, 32'h0);
    check("t1_full_in_ready", 32'(in_ready), 32'h0);
    do_reset();

    // 2: streaming with one-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0040_0000 + 32'(4 * i), 32'h8C08_0004 + 32'(4 * i));
      tick("t2_stream");
      check("t2_latency_pc", out_pc, 32'h0040_0000 + 32'(4 * i));
    end
    drive(1'b0, 32'h0, 32'h0);
    tick("t2_drain");

    // 3: skid fill then drain
    out_ready = 1'b0;
    drive(1'b1, 32'h100, 32'hAAAA_0100); tick("t3_a");
    drive(1'b1, 32'h104, 32'hBBBB_0104); tick("t3_b");
    check("t3_skid_in_ready", 32'(in_ready), 32'h0);
    check("t3_show_a", out_pc, 32'h100);
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    tick("t3_drain1");
    check("t3_show_b", out_pc, 32'h104);
    tick("t3_drain2");
    check("t3_empty", 32'(out_valid), 32'h0);

    // 4: flush while FULL with a simultaneous push
    out_ready = 1'b0;
    drive(1'b1, 32'h180, 32'h0000_0180); tick("t4_a");
    drive(1'b1, 32'h184, 32'h0000_0184); tick("t4_b");
    flush = 1'b1;
    drive(1'b1, 32'h200, 32'h0000_0200); tick("t4_flush");
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("t4_flushed_valid", 32'(out_valid), 32'h0);
    check("t4_flushed_ready", 32'(in_ready), 32'h1);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick("t4_after");
      check("t4_no_0x200", 32'(out_valid && out_pc == 32'h200), 32'h0);
    end

    // 5: back-pressure keeps the presented entry stable
    out_ready = 1'b0;
    drive(1'b1, 32'h300, 32'hCAFE_0300); tick("t5_load");
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0);
      tick("t5_hold");
      check("t5_pc_stable", out_pc, 32'h300);
      check("t5_data_stable", out_data, 32'hCAFE_0300);
    end
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick("t5_drain");

`ifdef PIPE_STAGE_PERF_EN
    // 6: counters saturate / count flushes
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h400, 32'h0000_0400); tick("t6_load");
    drive(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 20; i++) tick("t6_stall");
    check("t6_stall_sat", 32'(stall_cnt), 32'd15);
    out_ready = 1'b1;
    tick("t6_drain");
    flush = 1'b1;
    for (int i = 0; i < 3; i++) tick("t6_flush");
    flush = 1'b0;
    check("t6_flush_cnt", 32'(flush_cnt), 32'd3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
